// File: rtl/dcache_direct.sv
// rtl/dcache_direct.sv - direct-mapped write-back write-allocate data cache with line fill/evict port
module dcache_direct #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 3,
    parameter int TAG_ADDR_LEN  = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rd_req,
    input  logic                            wr_req,
    input  logic [31:0]                     addr,
    input  logic [3:0]                      wr_be,
    input  logic [31:0]                     wr_data,
    output logic [31:0]                     rd_data,
    output logic                            miss,
    output logic                            mem_rd_req,
    output logic                            mem_wr_req,
    output logic [31:0]                     mem_addr,
    output logic [(32<<LINE_ADDR_LEN)-1:0]  mem_wr_line,
    input  logic [(32<<LINE_ADDR_LEN)-1:0]  mem_rd_line,
    input  logic                            mem_gnt,
    output logic [31:0]                     hit_cnt,
    output logic [31:0]                     miss_cnt
);
    localparam int SETS      = 1 << SET_ADDR_LEN;
    localparam int LINE_BITS = 32 << LINE_ADDR_LEN;
    localparam int OFF_BITS  = LINE_ADDR_LEN + 2;

    typedef enum logic [1:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK} state_t;
    state_t state;

    logic [LINE_BITS-1:0]    line_mem [SETS];
    logic [TAG_ADDR_LEN-1:0] tag_mem  [SETS];
    logic [SETS-1:0]         valid;
    logic [SETS-1:0]         dirty;

    logic [LINE_ADDR_LEN-1:0] word_off;
    logic [SET_ADDR_LEN-1:0]  set_idx;
    logic [TAG_ADDR_LEN-1:0]  req_tag;
    logic                     addr_unused;
    logic                     req;
    logic                     hit;
    logic [LINE_BITS-1:0]     cur_line;
    logic [31:0]              cur_word;
    logic [LINE_BITS-1:0]     merged_line;

    logic [TAG_ADDR_LEN-1:0]  fill_tag;
    logic [SET_ADDR_LEN-1:0]  fill_set;
    logic [LINE_BITS-1:0]     fill_line;
    logic                     retry;

    assign word_off    = addr[OFF_BITS-1:2];
    assign set_idx     = addr[OFF_BITS +: SET_ADDR_LEN];
    assign req_tag     = addr[31 -: TAG_ADDR_LEN];
    assign addr_unused = ^addr[1:0];

    assign req      = rd_req | wr_req;
    assign hit      = valid[set_idx] && (tag_mem[set_idx] == req_tag);
    assign miss     = (state != IDLE) || (req && !hit);
    assign cur_line = line_mem[set_idx];
    assign cur_word = cur_line[{word_off, 5'b00000} +: 32];

    // Byte-lane merge of the store into the resident line
    always_comb begin
        merged_line = cur_line;
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
                merged_line[{word_off, 2'(b), 3'b000} +: 8] = wr_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            valid      <= '0;
            dirty      <= '0;
            rd_data    <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            retry      <= 1'b0;
            mem_rd_req <= 1'b0;
            mem_wr_req <= 1'b0;
            mem_addr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && hit) begin
                        // The first hit after a fill is the replay of an already counted miss
                        if (!retry) begin
                            hit_cnt <= hit_cnt + 32'd1;
                        end
                        retry <= 1'b0;
                        if (wr_req) begin
                            line_mem[set_idx] <= merged_line;
                            dirty[set_idx]    <= 1'b1;
                        end else begin
                            rd_data <= cur_word;
                        end
                    end else if (req) begin
                        miss_cnt <= miss_cnt + 32'd1;
                        fill_tag <= req_tag;
                        fill_set <= set_idx;
                        if (valid[set_idx] && dirty[set_idx]) begin
                            state       <= SWAP_OUT;
                            mem_wr_req  <= 1'b1;
                            mem_addr    <= {tag_mem[set_idx], set_idx, {OFF_BITS{1'b0}}};
                            mem_wr_line <= cur_line;
                        end else begin
                            state      <= SWAP_IN;
                            mem_rd_req <= 1'b1;
                            mem_addr   <= {req_tag, set_idx, {OFF_BITS{1'b0}}};
                        end
                    end
                end
                SWAP_OUT: begin
                    if (mem_gnt) begin
                        state      <= SWAP_IN;
                        mem_wr_req <= 1'b0;
                        mem_rd_req <= 1'b1;
                        mem_addr   <= {fill_tag, fill_set, {OFF_BITS{1'b0}}};
                    end
                end
                SWAP_IN: begin
                    if (mem_gnt) begin
                        state      <= SWAP_IN_OK;
                        mem_rd_req <= 1'b0;
                        mem_addr   <= '0;
                        fill_line  <= mem_rd_line;
                    end
                end
                SWAP_IN_OK: begin
                    state              <= IDLE;
                    line_mem[fill_set] <= fill_line;
                    tag_mem[fill_set]  <= fill_tag;
                    valid[fill_set]    <= 1'b1;
                    dirty[fill_set]    <= 1'b0;
                    retry              <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_direct.sv
// tb/tb_dcache_direct.sv - directed scoreboard bench for dcache_direct
module tb_dcache_direct;
    logic         clk = 1'b0;
    logic         rst;
    logic         rd_req, wr_req;
    logic [31:0]  addr;
    logic [3:0]   wr_be;
    logic [31:0]  wr_data;
    logic [31:0]  rd_data;
    logic         miss, mem_rd_req, mem_wr_req;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wr_line;
    logic [255:0] mem_rd_line;
    logic         mem_gnt;
    logic [31:0]  hit_cnt, miss_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q [$];

    dcache_direct dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
        .wr_be(wr_be), .wr_data(wr_data), .rd_data(rd_data), .miss(miss),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
        .mem_wr_line(mem_wr_line), .mem_rd_line(mem_rd_line), .mem_gnt(mem_gnt),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] make_line(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
        return l;
    endfunction

    task automatic pop_chk(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, rd_data, e);
        end
    endtask

    initial begin
        rst = 1'b1; rd_req = 0; wr_req = 0; addr = 0; wr_be = 0; wr_data = 0;
        mem_rd_line = '0; mem_gnt = 0;
        cycle(); cycle();
        rst = 1'b0;
        #1;
        chk("reset_rd_data", rd_data, 32'h0);
        chk("reset_hit_cnt", hit_cnt, 32'h0);
        chk("reset_miss_cnt", miss_cnt, 32'h0);
        chk("reset_miss", 32'(miss), 32'h0);
        chk("reset_mem_rd_req", 32'(mem_rd_req), 32'h0);
        chk("reset_mem_wr_req", 32'(mem_wr_req), 32'h0);

        // Clean miss on 0x40, grant five cycles into SWAP_IN
        rd_req = 1; addr = 32'h40;
        #1 chk("miss_comb", 32'(miss), 32'h1);
        cycle();
        chk("fill_rd_req", 32'(mem_rd_req), 32'h1);
        chk("fill_wr_req", 32'(mem_wr_req), 32'h0);
        chk("fill_addr", mem_addr, 32'h40);
        chk("fill_miss_cnt", miss_cnt, 32'h1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("swap_in_miss", 32'(miss), 32'h1);
        end
        mem_gnt = 1; mem_rd_line = make_line(32'h1000);
        cycle();
        mem_gnt = 0; mem_rd_line = '0;
        chk("swap_in_ok_miss", 32'(miss), 32'h1);
        chk("swap_in_ok_rd_req", 32'(mem_rd_req), 32'h0);
        chk("swap_in_ok_addr", mem_addr, 32'h0);
        cycle();
        chk("retry_hit_miss", 32'(miss), 32'h0);
        exp_q.push_back(32'h1000);
        cycle();
        rd_req = 0;
        pop_chk("rd_data_0x40");
        chk("after_fill_miss_cnt", miss_cnt, 32'h1);
        chk("after_fill_hit_cnt", hit_cnt, 32'h0);

        // Read hit on 0x44
        rd_req = 1; addr = 32'h44;
        #1 chk("hit44_miss", 32'(miss), 32'h0);
        exp_q.push_back(32'h1001);
        cycle();
        rd_req = 0;
        pop_chk("rd_data_0x44");
        chk("hit44_hit_cnt", hit_cnt, 32'h1);

        // Partial store then read back
        wr_req = 1; addr = 32'h44; wr_be = 4'b0011; wr_data = 32'hAAAABBBB;
        #1 chk("wr44_miss", 32'(miss), 32'h0);
        cycle();
        wr_req = 0;
        chk("wr44_no_rd_req", 32'(mem_rd_req), 32'h0);
        chk("wr44_no_wr_req", 32'(mem_wr_req), 32'h0);
        rd_req = 1; addr = 32'h44;
        exp_q.push_back(32'h0000BBBB);
        cycle();
        rd_req = 0;
        pop_chk("rd_data_merged");

        // Simultaneous read and write: write wins, rd_data holds
        rd_req = 1; wr_req = 1; addr = 32'h48; wr_be = 4'b1111; wr_data = 32'h12345678;
        cycle();
        wr_req = 0;
        chk("rdwr_rd_data_hold", rd_data, 32'h0000BBBB);
        exp_q.push_back(32'h12345678);
        cycle();
        rd_req = 0;
        pop_chk("rd_data_0x48");
        chk("hit_cnt_5", hit_cnt, 32'h5);
        chk("miss_cnt_still_1", miss_cnt, 32'h1);

        // Conflict miss on 0x140 evicts the dirty line
        rd_req = 1; addr = 32'h140;
        #1 chk("evict_miss_comb", 32'(miss), 32'h1);
        cycle();
        chk("evict_wr_req", 32'(mem_wr_req), 32'h1);
        chk("evict_rd_req", 32'(mem_rd_req), 32'h0);
        chk("evict_addr", mem_addr, 32'h40);
        chk("evict_word0", mem_wr_line[31:0], 32'h1000);
        chk("evict_word1", mem_wr_line[63:32], 32'h0000BBBB);
        chk("evict_word2", mem_wr_line[95:64], 32'h12345678);
        chk("evict_miss_cnt", miss_cnt, 32'h2);
        cycle();
        chk("evict_hold_wr_req", 32'(mem_wr_req), 32'h1);
        mem_gnt = 1;
        cycle();
        mem_gnt = 0;
        chk("refill_rd_req", 32'(mem_rd_req), 32'h1);
        chk("refill_wr_req", 32'(mem_wr_req), 32'h0);
        chk("refill_addr", mem_addr, 32'h140);
        cycle();

        // Reset while in SWAP_IN abandons the transfer
        rst = 1; rd_req = 0;
        cycle();
        rst = 0;
        #1;
        chk("rst_mid_rd_req", 32'(mem_rd_req), 32'h0);
        chk("rst_mid_wr_req", 32'(mem_wr_req), 32'h0);
        chk("rst_mid_addr", mem_addr, 32'h0);
        chk("rst_mid_miss", 32'(miss), 32'h0);
        chk("rst_mid_hit_cnt", hit_cnt, 32'h0);
        chk("rst_mid_miss_cnt", miss_cnt, 32'h0);
        chk("rst_mid_rd_data", rd_data, 32'h0);

        rd_req = 1; addr = 32'h44;
        #1 chk("post_rst_miss", 32'(miss), 32'h1);
        cycle();
        chk("post_rst_fill_addr", mem_addr, 32'h40);
        chk("post_rst_rd_req", 32'(mem_rd_req), 32'h1);
        mem_gnt = 1; mem_rd_line = make_line(32'h2000);
        cycle();
        mem_gnt = 0; mem_rd_line = '0;
        cycle();
        chk("post_rst_hit_miss", 32'(miss), 32'h0);
        exp_q.push_back(32'h2001);
        cycle();
        rd_req = 0;
        pop_chk("rd_data_post_rst");
        chk("post_rst_hit_cnt", hit_cnt, 32'h0);
        chk("post_rst_miss_cnt", miss_cnt, 32'h1);

        // Idle with a spurious grant
        for (int i = 0; i < 10; i++) begin
            mem_gnt = (i == 3);
            cycle();
            chk("idle_miss", 32'(miss), 32'h0);
            chk("idle_rd_req", 32'(mem_rd_req), 32'h0);
            chk("idle_wr_req", 32'(mem_wr_req), 32'h0);
        end
        mem_gnt = 0;
        chk("idle_hit_cnt", hit_cnt, 32'h0);
        chk("idle_miss_cnt", miss_cnt, 32'h1);
        chk("idle_rd_data", rd_data, 32'h2001);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
